// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-mode
// constants and a helper that returns the number of bit times in one frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        MARK
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int uart_frame_bits(input int dataBits,
                                           input int parityMode,
                                           input int stopBits);
        return 1 + dataBits + ((parityMode != PAR_NONE) ? 1 : 0) + stopBits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter shared by the UART transmitter and the planned receiver.
// Counts 0..BAUD_DIV-1 while enabled and flags the terminal count for one
// cycle. A synchronous clear parks the counter at zero so a new bit period
// always starts with a full BAUD_DIV cycles.
module uart_baud_tick #(
    parameter int BAUD_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_count;

    // Free-running bit-period counter, wrapping on the terminal count.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (r_count == TERMINAL) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_tick = i_enable && (r_count == TERMINAL);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a valid/ready word interface.
// Frame: start bit, DATA_BITS data bits LSB first, optional even/odd parity,
// STOP_BITS stop bits. All outputs are registered; tx_done pulses for one
// cycle as the final stop bit ends, which is also the first ready cycle.
// Optional break generator enabled by defining UART_TX_FRAME_BREAK_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = 100,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_TX_FRAME_BREAK_EN
    input  logic                 tx_break,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Refuse to elaborate a configuration the frame logic cannot represent.
    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_badParams
        $error("uart_tx_frame: illegal parameter combination");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_TX_FRAME_BREAK_EN
    localparam logic [3:0] LAST_FRAME =
        4'(uart_frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS) - 1);
`endif

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [3:0]           r_bitIdx;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_tick;
    logic                 w_clear;
    logic                 w_breakReq;

`ifdef UART_TX_FRAME_BREAK_EN
    assign w_breakReq = tx_break;
`else
    assign w_breakReq = 1'b0;
`endif

    // The bit timer is held at zero in IDLE so the start bit gets a full period.
    assign w_clear = (r_state == IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baudTick (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (!w_clear),
        .o_tick   (w_tick)
    );

    // Frame sequencer; every output is produced from a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_bitIdx <= '0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx     <= 1'b1;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_bitIdx <= '0;
                    if (w_breakReq) begin
                        r_state <= BREAK;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (tx_valid && r_ready) begin
                        r_shift  <= tx_data;
                        r_parity <= (^tx_data) ^ (PARITY_MODE == PAR_ODD);
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bitIdx == LAST_DATA) begin
                            r_bitIdx <= '0;
                            if (PARITY_MODE != PAR_NONE) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                            r_tx     <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_bitIdx == LAST_STOP) begin
                            r_state  <= IDLE;
                            r_bitIdx <= '0;
                            r_done   <= 1'b1;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_FRAME_BREAK_EN
                BREAK: begin
                    // Hold the line low for at least one frame, longer while requested.
                    if (w_tick) begin
                        if (r_bitIdx == LAST_FRAME) begin
                            if (!tx_break) begin
                                r_state  <= MARK;
                                r_tx     <= 1'b1;
                                r_bitIdx <= '0;
                            end
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule
